win_valid_genr: RTL and testbench
=================================

# win_valid_genr

Output-side position tracker for the parallel convolution line-buffer pipeline. It counts accepted pixel groups per row and per frame. From that count it derives:
- per-lane window-valid flags;
- the active-low row-start edge mask that pairs with `rowend_sig_genr`;
- a frame-done pulse.

It sits after the line buffers and kernel datapath. It tells the write-back stage which of the NO_PARALLEL_UNITS results in each group are full KER_SIZE×KER_SIZE windows.

## Interface
- IM_LEN, 16'd520: image width in pixels; must be a multiple of NO_PARALLEL_UNITS.
- IM_HEIGHT, 16'd520: image height in rows.
- KER_SIZE, 3: kernel edge length; must be ≥ 2.
- NO_PARALLEL_UNITS, 4: pixels per group (P).
- clk  in  1  clock; all state updates on rising edge.
- res  in  1  reset, synchronous, active-high.
- clrbuffer  in  1  synchronous clear; same effect as res.
- stall  in  1  pipeline stall; freezes all counters.
- in_valid  in  1  a pixel group is presented this cycle.
- row_start  out  KER_SIZE-1  active-low left-edge mask, combinational from col_cnt.
- out_valid  out  1  registered; one group's results are on the datapath output.
- lane_valid  out  P  registered; bit j is 1 when lane j holds a full window.
- frame_done  out  1  registered one-cycle pulse after the last group of a frame.
- col_cnt  out  11  current group column, 0..C-1, where C = IM_LEN/P.
- row_cnt  out  11  current row, 0..IM_HEIGHT-1.

## Operation
- Accept condition is acc = in_valid & !stall.
- col_cnt increments on acc.
  - When col_cnt == C-1 and acc: col_cnt → 0 and row_cnt increments.
  - When row_cnt == IM_HEIGHT-1 at that wrap: row_cnt → 0 as well (frame wrap).
- Without acc, col_cnt and row_cnt hold. Wrap never occurs without acc, including the case where the count is at C-1 while stalled.
- row_start[i] = 0 when col_cnt == i, else 1, for i in 0..KER_SIZE-2. This is the mirror of the row-end mask.
- Lane pixel index is x = col_cnt·P + j.
  - On acc, the next-cycle lane_valid[j] = 1 iff row_cnt ≥ KER_SIZE-1 and x ≥ KER_SIZE-1.
  - Windows are right/bottom-edge aligned, so the first KER_SIZE-1 rows and the first KER_SIZE-1 pixels of every row are invalid.
- out_valid is acc registered.
- When acc is low, out_valid = 0 and lane_valid = 0 the next cycle.
- frame_done is acc & (col_cnt == C-1) & (row_cnt == IM_HEIGHT-1), registered.
- res or clrbuffer wins over acc in the same cycle. After the clock edge:
  - col_cnt = 0, row_cnt = 0;
  - out_valid = 0, lane_valid = 0, frame_done = 0;
  - row_start = {KER_SIZE-1{1}} except bit 0 = 0.
- Comparisons are done at ≥ 16-bit width so that col_cnt·P does not overflow.

## Timing
- Latency is 1 cycle from accept to out_valid, lane_valid and frame_done.
- row_start has zero latency; it follows col_cnt in the same cycle.
- stall high: counters hold, and out_valid and lane_valid fall to 0 the next cycle. Acceptance resumes in the first cycle with stall low and in_valid high.
- Back-to-back accepts produce one output per cycle with no bubbles.
- frame_done is high for exactly 1 cycle per frame. It coincides with the out_valid of the last group.
- Reset or clear mid-frame discards position. The next accepted group is treated as row 0, column 0.

## Test plan
All scenarios use IM_LEN=16, IM_HEIGHT=4, KER_SIZE=3, P=4, so C=4.
- Reset: hold res 2 cycles, then release → col_cnt=0, row_cnt=0, row_start=2'b10, out_valid=0, lane_valid=0, frame_done=0.
- Priming rows: 8 consecutive accepts (rows 0–1) → out_valid=1 each cycle, lane_valid=4'b0000 throughout, row_start=2'b01 when col_cnt=1.
- Valid region: continue to row 2 → lane_valid=4'b1100 for col 0 and 4'b1111 for cols 1–3. row_cnt=3 after the 12th accept.
- Frame wrap: 16th accept → frame_done=1 for one cycle together with lane_valid=4'b1111. Afterwards col_cnt=0, row_cnt=0.
- Stall: at col_cnt=3, row 2, hold stall=1 with in_valid=1 for 3 cycles → col_cnt stays 3, out_valid=0 for those cycles. Drop stall → one accept, col_cnt=0, row_cnt=3.
- Clear priority: clrbuffer=1 with acc=1 at col_cnt=2, row_cnt=3 → next cycle all counters are 0, out_valid=0, frame_done=0.

Source files
------------

// File: rtl/win_valid_genr.sv
// Output-side position tracker for the parallel convolution pipeline: counts accepted
// pixel groups per row/frame and derives per-lane window-valid flags and frame-done.
module win_valid_genr #(
  parameter logic [15:0] IM_LEN            = 16'd520,
  parameter logic [15:0] IM_HEIGHT         = 16'd520,
  parameter int          KER_SIZE          = 3,
  parameter int          NO_PARALLEL_UNITS = 4
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic                         clrbuffer,
  input  logic                         stall,
  input  logic                         in_valid,
  output logic [KER_SIZE-2:0]          row_start,
  output logic                         out_valid,
  output logic [NO_PARALLEL_UNITS-1:0] lane_valid,
  output logic                         frame_done,
  output logic [10:0]                  col_cnt,
  output logic [10:0]                  row_cnt
);

  localparam logic [15:0] COLS = 16'(IM_LEN / 16'(NO_PARALLEL_UNITS));

  logic acc_s;
  logic col_last_s;
  logic row_last_s;

  // Lane j is a full window once both the row and its pixel index are past the kernel
  // border; done at 32 bits so col*P cannot overflow.
  function automatic logic [NO_PARALLEL_UNITS-1:0] lane_mask(input logic [10:0] col,
                                                             input logic [10:0] row);
    logic [31:0] x;
    logic [NO_PARALLEL_UNITS-1:0] m;
    m = '0;
    for (int j = 0; j < NO_PARALLEL_UNITS; j++) begin
      x = 32'(col) * 32'(NO_PARALLEL_UNITS) + 32'(j);
      m[j] = (32'(row) >= 32'(KER_SIZE - 1)) && (x >= 32'(KER_SIZE - 1));
    end
    return m;
  endfunction

  // Accept qualification and end-of-row / end-of-frame detection.
  always_comb begin
    acc_s      = in_valid & ~stall;
    col_last_s = ({5'd0, col_cnt} == (COLS - 16'd1));
    row_last_s = ({5'd0, row_cnt} == (IM_HEIGHT - 16'd1));
  end

  // Active-low left-edge mask, mirror of the row-end mask.
  always_comb begin
    row_start = '1;
    for (int i = 0; i < KER_SIZE - 1; i++) begin
      if (col_cnt == 11'(i)) begin
        row_start[i] = 1'b0;
      end else begin
        row_start[i] = 1'b1;
      end
    end
  end

  // Position counters and registered output flags; reset/clear beats an accept.
  always_ff @(posedge clk) begin
    if (res || clrbuffer) begin
      col_cnt    <= 11'd0;
      row_cnt    <= 11'd0;
      out_valid  <= 1'b0;
      lane_valid <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= acc_s;
      lane_valid <= acc_s ? lane_mask(col_cnt, row_cnt) : '0;
      frame_done <= acc_s & col_last_s & row_last_s;
      if (acc_s) begin
        if (col_last_s) begin
          col_cnt <= 11'd0;
          row_cnt <= row_last_s ? 11'd0 : (row_cnt + 11'd1);
        end else begin
          col_cnt <= col_cnt + 11'd1;
          row_cnt <= row_cnt;
        end
      end else begin
        col_cnt <= col_cnt;
        row_cnt <= row_cnt;
      end
    end
  end

endmodule

// File: tb/tb_win_valid_genr.sv
// Scoreboard bench for win_valid_genr on a 16x4 image, 3x3 kernel, 4 lanes (4 groups/row).
module tb_win_valid_genr;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        clrbuffer = 1'b0;
  logic        stall = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  row_start;
  logic        out_valid;
  logic [3:0]  lane_valid;
  logic        frame_done;
  logic [10:0] col_cnt;
  logic [10:0] row_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  int mr = 0;
  int mc = 0;
  logic [4:0] exp_q[$];

  win_valid_genr #(
    .IM_LEN(16'd16), .IM_HEIGHT(16'd4), .KER_SIZE(3), .NO_PARALLEL_UNITS(4)
  ) dut (
    .clk(clk), .res(res), .clrbuffer(clrbuffer), .stall(stall), .in_valid(in_valid),
    .row_start(row_start), .out_valid(out_valid), .lane_valid(lane_valid),
    .frame_done(frame_done), .col_cnt(col_cnt), .row_cnt(row_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-derived expectation: rows 0-1 invalid; rows 2-3 col 0 -> 1100, else 1111.
  function automatic logic [4:0] expect_of(input int r, input int c);
    logic [3:0] l;
    if (r < 2)       l = 4'b0000;
    else if (c == 0) l = 4'b1100;
    else             l = 4'b1111;
    return {l, (r == 3 && c == 3)};
  endfunction

  task automatic accept(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      stall    = 1'b0;
      exp_q.push_back(expect_of(mr, mc));
      mc++;
      if (mc == 4) begin
        mc = 0;
        mr++;
        if (mr == 4) mr = 0;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Monitor: every presented output is matched against the oldest expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          chk("lane_valid", 32'(lane_valid), 32'(e[4:1]));
          chk("frame_done", 32'(frame_done), 32'(e[0]));
        end
      end else begin
        chk("idle_lane_valid", 32'(lane_valid), 32'd0);
        chk("idle_frame_done", 32'(frame_done), 32'd0);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    res = 1'b0;
    chk("rst_col", 32'(col_cnt), 32'd0);
    chk("rst_row", 32'(row_cnt), 32'd0);
    chk("rst_row_start", 32'(row_start), 32'b10);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_lane_valid", 32'(lane_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    mon_en = 1'b1;

    accept(1);
    chk("row_start_col1", 32'(row_start), 32'b01);
    accept(7);
    chk("prime_row", 32'(row_cnt), 32'd2);
    chk("prime_col", 32'(col_cnt), 32'd0);
    chk("prime_row_start", 32'(row_start), 32'b10);
    accept(4);
    chk("valid_row", 32'(row_cnt), 32'd3);
    accept(4);
    chk("wrap_col", 32'(col_cnt), 32'd0);
    chk("wrap_row", 32'(row_cnt), 32'd0);
    chk("wrap_row_start", 32'(row_start), 32'b10);

    // Stall at row 2, col 3.
    accept(11);
    chk("pre_stall_col", 32'(col_cnt), 32'd3);
    chk("pre_stall_row", 32'(row_cnt), 32'd2);
    in_valid = 1'b1;
    stall    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall_col", 32'(col_cnt), 32'd3);
      chk("stall_row", 32'(row_cnt), 32'd2);
      chk("stall_out_valid", 32'(out_valid), 32'd0);
      chk("stall_row_start", 32'(row_start), 32'b11);
    end
    accept(1);
    chk("post_stall_col", 32'(col_cnt), 32'd0);
    chk("post_stall_row", 32'(row_cnt), 32'd3);

    // Clear beats an accept at row 3, col 2.
    accept(2);
    chk("pre_clr_col", 32'(col_cnt), 32'd2);
    clrbuffer = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    clrbuffer = 1'b0;
    in_valid  = 1'b0;
    mr = 0;
    mc = 0;
    chk("clr_col", 32'(col_cnt), 32'd0);
    chk("clr_row", 32'(row_cnt), 32'd0);
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_lane_valid", 32'(lane_valid), 32'd0);
    chk("clr_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1;
    accept(1);
    chk("post_clr_col", 32'(col_cnt), 32'd1);
    chk("post_clr_row", 32'(row_cnt), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
